// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor.
// Holds the FSM state enum and width helpers.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PRST,
    WAIT,
    STAB,
    RUN,
    FAIL
  } pll_sup_state_t;

  localparam int RETRY_W = 4;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single
// asynchronous level, async active-low reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on refclk; gates sys_rst_n on stable lock.
// Optional loss counter: PLL_LOCK_SUPERVISOR_LOSS_CNT_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 1000000,
  parameter int STABLE_CYCLES  = 65536,
  parameter int MAX_RETRIES    = 7
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               locked,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               failed
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  ,
  output logic [7:0]         loss_cnt
`endif
);

  localparam int CNT_MAX =
    max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] PRST_END =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_END =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_END =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  pll_sup_state_t     r_state;
  pll_sup_state_t     w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic [RETRY_W-1:0] w_retry_inc;
  logic               w_fail_hit;
  logic               w_lk_s;

  sync_2ff u_lock_sync (
    .i_clk   (refclk),
    .i_rst_n (rst_n),
    .i_d     (locked),
    .o_q     (w_lk_s)
  );

  assign w_retry_inc = (r_retry == RETRY_SAT)
                     ? r_retry
                     : r_retry + 1'b1;

  assign w_fail_hit = (MAX_RETRIES != 0) &&
                      (int'(w_retry_inc) >= MAX_RETRIES);

  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_retry_nxt = r_retry;
    unique case (r_state)
      PRST: begin
        if (r_cnt == PRST_END) w_next = WAIT;
      end
      WAIT: begin
        // Lock beats a same-cycle timeout.
        if (w_lk_s) begin
          w_next = STAB;
        end else if (r_cnt == TO_END) begin
          w_retry_nxt = w_retry_inc;
          w_next      = w_fail_hit ? FAIL : PRST;
        end
      end
      STAB: begin
        if (!w_lk_s) begin
          w_next = WAIT;
        end else if (r_cnt == STAB_END) begin
          w_next = RUN;
        end
      end
      RUN: begin
        w_cnt_nxt = '0;
        if (!w_lk_s) w_next = WAIT;
      end
      FAIL: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_next = PRST;
      end
    endcase
    if (w_next != r_state) w_cnt_nxt = '0;
  end

  // Outputs register the next state so they align with r_state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= PRST;
      r_cnt     <= '0;
      r_retry   <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      failed    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_nxt;
      r_retry   <= w_retry_nxt;
      pll_rst   <= (w_next == PRST) ||
                   (w_next == FAIL);
      sys_rst_n <= (w_next == RUN);
      failed    <= (w_next == FAIL);
    end
  end

  assign retry_cnt = r_retry;

`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  logic [7:0] r_loss;
  logic       w_run_exit;

  assign w_run_exit = (r_state == RUN) && !w_lk_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss <= '0;
    end else if (w_run_exit && (r_loss != 8'hFF)) begin
      r_loss <= r_loss + 1'b1;
    end
  end

  assign loss_cnt = r_loss;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized + directed bench for pll_lock_supervisor
// against a duration-based reference model.
module tb_pll_lock_supervisor;

  localparam int PRC = 4;
  localparam int TO  = 20;
  localparam int ST  = 8;
  localparam int MR  = 2;

  localparam int P_PRST = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;
  localparam int P_FAIL = 4;

  logic       refclk;
  logic       rst_n;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic [3:0] retry_cnt;
  logic       failed;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int n_vec;
  int n_err;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (TO),
    .STABLE_CYCLES  (ST),
    .MAX_RETRIES    (MR)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .locked    (locked),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .retry_cnt (retry_cnt),
    .failed    (failed)
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    ,
    .loss_cnt  (loss_cnt)
`endif
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d",
               nm, $time, act, exp);
    end
  endtask

  // Reference: phase plus cycles elapsed in that phase,
  // decisions made on the locked level seen two edges ago.
  int m_ph;
  int m_el;
  int m_retry;
  int m_loss;
  bit m_s1;
  bit m_s2;

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = P_PRST; m_el = 0; m_retry = 0;
      m_loss = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      case (m_ph)
        P_PRST: begin
          m_el++;
          if (m_el == PRC) begin m_ph = P_WAIT; m_el = 0; end
        end
        P_WAIT: begin
          if (m_s2) begin
            m_ph = P_STAB; m_el = 0;
          end else begin
            m_el++;
            if (m_el == TO) begin
              if (m_retry < 15) m_retry++;
              m_ph = (MR != 0 && m_retry >= MR) ? P_FAIL : P_PRST;
              m_el = 0;
            end
          end
        end
        P_STAB: begin
          if (!m_s2) begin
            m_ph = P_WAIT; m_el = 0;
          end else begin
            m_el++;
            if (m_el == ST) begin m_ph = P_RUN; m_el = 0; end
          end
        end
        P_RUN: begin
          if (!m_s2) begin
            m_ph = P_WAIT; m_el = 0;
            if (m_loss < 255) m_loss++;
          end
        end
        default: ;
      endcase
      m_s2 = m_s1;
      m_s1 = locked;
    end
  end

  always @(negedge refclk) begin
    check("pll_rst", int'(pll_rst),
          int'(m_ph == P_PRST || m_ph == P_FAIL));
    check("sys_rst_n", int'(sys_rst_n), int'(m_ph == P_RUN));
    check("failed", int'(failed), int'(m_ph == P_FAIL));
    check("retry_cnt", int'(retry_cnt), m_retry);
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    check("loss_cnt", int'(loss_cnt), m_loss);
`endif
  end

  task automatic step();
    @(posedge refclk);
    #2;
  endtask

  task automatic do_reset();
    step();
    #($urandom_range(0, 2));
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  int n;
  int len;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    locked = 1'b0;
    #13;
    check("rst_pll_rst", int'(pll_rst), 1);
    check("rst_sys_rst_n", int'(sys_rst_n), 0);
    check("rst_retry", int'(retry_cnt), 0);
    check("rst_failed", int'(failed), 0);

    // No lock at all: two timeouts then FAIL.
    do_reset();
    repeat (3) step();
    check("prst_len_hi", int'(pll_rst), 1);
    step();
    check("prst_len_lo", int'(pll_rst), 0);
    repeat (19) step();
    check("wait_len", int'(pll_rst), 0);
    step();
    check("retry1_prst", int'(pll_rst), 1);
    check("retry1_cnt", int'(retry_cnt), 1);
    repeat (24) step();
    check("fail_flag", int'(failed), 1);
    check("fail_retry", int'(retry_cnt), 2);
    check("fail_pll_rst", int'(pll_rst), 1);
    repeat (50) step();
    check("fail_hold", int'(failed), 1);
    check("fail_hold_sys", int'(sys_rst_n), 0);

    // Clean lock 5 cycles into WAIT: 11 edges to release.
    do_reset();
    repeat (8) step();
    locked = 1'b1;
    n = 61;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (sys_rst_n) begin n = i; break; end
    end
    check("lock_latency", n, 11);
    check("lock_retry", int'(retry_cnt), 0);

    // One-cycle glitch restarts qualification.
    locked = 1'b0;
    do_reset();
    repeat (8) step();
    locked = 1'b1;
    n = 61;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (i == 5) locked = 1'b0;
      if (i == 6) locked = 1'b1;
      if (sys_rst_n) begin n = i; break; end
    end
    check("glitch_latency", n, 17);

    // Lock seen on the timeout cycle wins.
    locked = 1'b0;
    do_reset();
    repeat (21) step();
    locked = 1'b1;
    repeat (3) step();
    check("tie_pll_rst", int'(pll_rst), 0);
    check("tie_retry", int'(retry_cnt), 0);
    repeat (8) step();
    check("tie_run", int'(sys_rst_n), 1);

    // Loss in RUN.
    locked = 1'b0;
    repeat (3) step();
    check("loss_sys", int'(sys_rst_n), 0);
    check("loss_pll", int'(pll_rst), 0);
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    check("loss_cnt1", int'(loss_cnt), 1);
`endif
    locked = 1'b1;
    repeat (11) step();
    check("relock_run", int'(sys_rst_n), 1);

    // Async reset from RUN.
    rst_n = 1'b0;
    #1;
    check("async_sys", int'(sys_rst_n), 0);
    check("async_pll", int'(pll_rst), 1);
    check("async_retry", int'(retry_cnt), 0);
    step();
    rst_n = 1'b1;
    locked = 1'b0;
    repeat (3) step();
    check("restart_prst", int'(pll_rst), 1);
    step();
    check("restart_wait", int'(pll_rst), 0);

    // Random lock waveforms.
    for (int t = 0; t < 12; t++) begin
      locked = 1'b0;
      do_reset();
      for (int c = 0; c < 400; c += len) begin
        len = $urandom_range(1, 40);
        locked = ($urandom_range(0, 3) != 0);
        repeat (len) step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
